// File: rtl/pp_net_tx_arbiter.sv
// rtl/pp_net_tx_arbiter.sv - round-robin owner of the shared network TX link for PP requesters
module pp_net_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SIZE_W  = 11,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_abort,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      net_msg_stored,
  output logic [SIZE_W-1:0]         net_size,
  input  logic                      net_busy_tx,
  input  logic                      net_msg_accessed,
  output logic                      timeout_err,
  output logic [2:0]                state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    WAIT_ACC = 3'd2,
    RELEASE  = 3'd3
  } state_t;

  state_t           fsm;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_found;
  logic [31:0]      cnt;
  logic             expire;
  logic [SIZE_W-1:0] size_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      size_arr[i] = req_size[i*SIZE_W +: SIZE_W];
    end
  end

  // Search starts one past the last owner so the previous owner is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign expire = (cnt == 32'(TIMEOUT - 1));
  assign state  = fsm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm            <= IDLE;
      ptr            <= IDX_W'(NUM_REQ - 1);
      owner          <= '0;
      cnt            <= '0;
      grant          <= '0;
      net_msg_stored <= 1'b0;
      net_size       <= '0;
      req_done       <= '0;
      req_abort      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      req_done  <= '0;
      req_abort <= '0;
      case (fsm)
        IDLE: begin
          if (sel_found && !net_busy_tx) begin
            owner          <= sel_idx;
            grant          <= NUM_REQ'(1) << sel_idx;
            net_msg_stored <= 1'b1;
            net_size       <= size_arr[sel_idx];
            cnt            <= '0;
            fsm            <= GRANT;
          end
        end
        GRANT: begin
          cnt <= cnt + 32'd1;
          if (expire) begin
            req_abort      <= NUM_REQ'(1) << owner;
            timeout_err    <= 1'b1;
            grant          <= '0;
            net_msg_stored <= 1'b0;
            net_size       <= '0;
            ptr            <= owner;
            fsm            <= IDLE;
          end else if (net_busy_tx) begin
            net_msg_stored <= 1'b0;
            fsm            <= WAIT_ACC;
          end else if (!req_valid[owner]) begin
            grant          <= '0;
            net_msg_stored <= 1'b0;
            net_size       <= '0;
            ptr            <= owner;
            fsm            <= IDLE;
          end
        end
        WAIT_ACC: begin
          cnt <= cnt + 32'd1;
          // A delivery seen on the expiry cycle still counts as delivered.
          if (net_msg_accessed) begin
            req_done <= NUM_REQ'(1) << owner;
            fsm      <= RELEASE;
          end else if (expire) begin
            req_abort      <= NUM_REQ'(1) << owner;
            timeout_err    <= 1'b1;
            grant          <= '0;
            net_msg_stored <= 1'b0;
            net_size       <= '0;
            ptr            <= owner;
            fsm            <= IDLE;
          end
        end
        RELEASE: begin
          if (!net_busy_tx) begin
            grant    <= '0;
            net_size <= '0;
            ptr      <= owner;
            fsm      <= IDLE;
          end
        end
        default: begin
          grant          <= '0;
          net_msg_stored <= 1'b0;
          net_size       <= '0;
          fsm            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_net_tx_arbiter.sv
// tb/tb_pp_net_tx_arbiter.sv - scoreboard bench for pp_net_tx_arbiter
module tb_pp_net_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SIZE_W  = 11;
  localparam int TIMEOUT = 128;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*SIZE_W-1:0] req_size;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_abort;
  logic [NUM_REQ-1:0]        grant;
  logic                      net_msg_stored;
  logic [SIZE_W-1:0]         net_size;
  logic                      net_busy_tx;
  logic                      net_msg_accessed;
  logic                      timeout_err;
  logic [2:0]                state;

  pp_net_tx_arbiter #(.NUM_REQ(NUM_REQ), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_size(req_size),
    .req_done(req_done), .req_abort(req_abort), .grant(grant),
    .net_msg_stored(net_msg_stored), .net_size(net_size),
    .net_busy_tx(net_busy_tx), .net_msg_accessed(net_msg_accessed),
    .timeout_err(timeout_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int kind; int idx; int size; } ev_t;
  ev_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int size_of(input int i);
    return 300 + 17 * i;
  endfunction

  task automatic push_ev(input int kind, input int idx);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.size = size_of(idx);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [NUM_REQ-1:0] vec);
    ev_t e;
    logic [NUM_REQ-1:0] onehot;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, 99);
      return;
    end
    e = exp_q.pop_front();
    onehot = NUM_REQ'(1) << e.idx;
    check("event_kind", kind, e.kind);
    check("event_owner", vec, onehot);
    if (kind == EV_GRANT) begin
      check("net_size", net_size, e.size);
      check("stored_at_grant", net_msg_stored, 1);
    end
  endtask

  always @(negedge clk) begin
    if (req_done != '0) pop_check(EV_DONE, req_done);
    if (req_abort != '0) pop_check(EV_ABORT, req_abort);
    if (grant != '0 && prev_grant == '0) pop_check(EV_GRANT, grant);
    if (grant != '0 && prev_grant != '0 && grant != prev_grant) check("grant_handover", grant, prev_grant);
    if ($countones(grant) > 1) check("grant_onehot", $countones(grant), 1);
    prev_grant = grant;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant();
    int cyc;
    cyc = 0;
    while (grant == '0 && cyc < 300) begin
      step(1);
      cyc++;
    end
    check("grant_latency", cyc, 1);
  endtask

  task automatic serve(input int idx, input int acc_dly);
    logic [NUM_REQ-1:0] onehot;
    onehot = NUM_REQ'(1) << idx;
    step(2);
    net_busy_tx = 1'b1;
    step(1);
    check("stored_drop", net_msg_stored, 0);
    check("wait_state", state, 2);
    step(acc_dly);
    net_msg_accessed = 1'b1;
    push_ev(EV_DONE, idx);
    step(1);
    net_msg_accessed = 1'b0;
    check("release_state", state, 3);
    step(1);
    check("grant_held", grant, onehot);
    net_busy_tx = 1'b0;
    step(1);
    check("idle_after_release", state, 0);
    check("grant_cleared", grant, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_valid = '0;
    net_busy_tx = 1'b0;
    net_msg_accessed = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_size[i*SIZE_W +: SIZE_W] = SIZE_W'(size_of(i));
    step(3);
    check("rst_grant", grant, 0);
    check("rst_stored", net_msg_stored, 0);
    check("rst_size", net_size, 0);
    check("rst_done", req_done, 0);
    check("rst_abort", req_abort, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_state", state, 0);
    rst_n = 1'b1;
    step(1);

    // single request
    req_valid = 4'b0001;
    push_ev(EV_GRANT, 0);
    wait_grant();
    check("grant_state", state, 1);
    serve(0, 100);
    req_valid = '0;
    step(2);

    // busy link blocks arbitration
    net_busy_tx = 1'b1;
    req_valid = 4'b0001;
    step(5);
    check("busy_no_grant", grant, 0);
    net_busy_tx = 1'b0;
    push_ev(EV_GRANT, 0);
    wait_grant();
    serve(0, 5);
    req_valid = '0;

    // round robin from reset
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_ev(EV_GRANT, k % NUM_REQ);
      wait_grant();
      serve(k % NUM_REQ, 5);
    end
    req_valid = '0;
    step(2);

    // timeout then next requester
    req_valid = 4'b0110;
    push_ev(EV_GRANT, 1);
    wait_grant();
    push_ev(EV_ABORT, 1);
    cyc = 0;
    while (req_abort == '0 && cyc < 300) begin
      step(1);
      cyc++;
      if (cyc == 2) net_busy_tx = 1'b1;
    end
    check("abort_latency", cyc, 128);
    check("terr_set", timeout_err, 1);
    check("abort_grant_clr", grant, 0);
    req_valid = 4'b0100;
    net_busy_tx = 1'b0;
    push_ev(EV_GRANT, 2);
    wait_grant();
    serve(2, 5);
    req_valid = '0;
    step(2);
    check("terr_sticky", timeout_err, 1);

    // withdrawal in GRANT
    req_valid = 4'b0001;
    push_ev(EV_GRANT, 0);
    wait_grant();
    step(1);
    req_valid = '0;
    step(1);
    check("wd_grant", grant, 0);
    check("wd_stored", net_msg_stored, 0);
    check("wd_state", state, 0);
    step(3);
    req_valid = 4'b0011;
    push_ev(EV_GRANT, 1);
    wait_grant();
    serve(1, 3);
    req_valid = '0;
    step(2);

    // reset during WAIT_ACC
    req_valid = 4'b0001;
    push_ev(EV_GRANT, 0);
    wait_grant();
    step(2);
    net_busy_tx = 1'b1;
    step(2);
    check("pre_rst_state", state, 2);
    rst_n = 1'b0;
    req_valid = 4'b0011;
    net_busy_tx = 1'b0;
    step(1);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_stored", net_msg_stored, 0);
    check("mid_rst_size", net_size, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    push_ev(EV_GRANT, 0);
    wait_grant();
    serve(0, 3);
    req_valid = '0;
    step(2);

    // delivery on the expiry cycle
    req_valid = 4'b0001;
    push_ev(EV_GRANT, 0);
    wait_grant();
    cyc = 0;
    while (cyc < 127) begin
      step(1);
      cyc++;
      if (cyc == 2) net_busy_tx = 1'b1;
    end
    net_msg_accessed = 1'b1;
    push_ev(EV_DONE, 0);
    step(1);
    net_msg_accessed = 1'b0;
    check("sim_terr", timeout_err, 0);
    check("sim_state", state, 3);
    step(1);
    net_busy_tx = 1'b0;
    step(1);
    req_valid = '0;
    check("sim_idle", state, 0);
    step(4);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
